// File: rtl/nco_dac_serial_tx.sv
`default_nettype none
// ============================================================================
// Module  : nco_dac_serial_tx
// Brief   : FIFO-buffered NCO sample sink driving a 3-wire serial DAC frame
// Revision: 1.0
// ============================================================================
module nco_dac_serial_tx #(
  parameter int MPR    = 14,
  parameter int DW     = 16,
  parameter int CLKDIV = 4,
  parameter int GAPC   = 2,
  parameter int FDL2   = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clken,
  input  logic [MPR-1:0] fsin_i,
  input  logic           in_valid,
  output logic           dac_sclk,
  output logic           dac_sync_n,
  output logic           dac_sdin,
  output logic           overflow,
  output logic           busy,
  output logic [FDL2:0]  fifo_level
);

  localparam int DEPTH = 1 << FDL2;
  localparam int DIVW  = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GAPW  = (GAPC > 1) ? $clog2(GAPC) : 1;
  localparam int BITW  = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [MPR-1:0]  mem_q [DEPTH];
  logic [FDL2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FDL2:0]   count_q, count_d;
  logic            ne_q, ovf_q, busy_q;
  logic [1:0]      state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [BITW-1:0] bit_q, bit_d;
  logic [GAPW-1:0] gap_q, gap_d;
  logic            sclk_q, sclk_d, sync_q, sync_d;
  logic            w_push, w_pop, w_full;
  logic [MPR-1:0]  w_head;
  logic [DW-1:0]   w_frame;

  assign w_full  = (count_q == (FDL2+1)'(DEPTH));
  assign w_push  = clken & in_valid & ~w_full;
  assign w_pop   = (state_q == S_LOAD);
  assign w_head  = mem_q[rd_ptr_q];
  assign w_frame = DW'({~w_head[MPR-1], w_head[MPR-2:0]});

  always_comb begin
    count_d = count_q;
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    case (state_q)
      // ne_q lags the count by a cycle; the live count guards against a stale flag
      S_IDLE: if (ne_q && (count_q != '0)) state_d = S_LOAD;
      S_LOAD: begin
        sr_d    = w_frame;
        sync_d  = 1'b0;
        sclk_d  = 1'b1;
        div_d   = '0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == DIVW'(CLKDIV-1)) begin
          div_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_q == BITW'(DW-1)) begin
            sclk_d  = 1'b1;
            sync_d  = 1'b1;
            sr_d    = '0;
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            sclk_d = 1'b1;
            sr_d   = {sr_q[DW-2:0], 1'b0};
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GAPW'(GAPC-1)) state_d = S_IDLE;
        else                        gap_d   = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= fsin_i;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ne_q     <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      state_q  <= S_IDLE;
      sr_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      sclk_q   <= 1'b1;
      sync_q   <= 1'b1;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (clken && in_valid && w_full) ovf_q <= 1'b1;
      count_q <= count_d;
      ne_q    <= (count_q != '0);
      busy_q  <= (state_d != S_IDLE) || (count_d != '0);
      state_q <= state_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
    end
  end

  assign dac_sclk   = sclk_q;
  assign dac_sync_n = sync_q;
  assign dac_sdin   = sr_q[DW-1];
  assign overflow   = ovf_q;
  assign busy       = busy_q;
  assign fifo_level = count_q;

endmodule
`default_nettype wire
